// File: rtl/reg_read_stage.sv
// reg_read_stage: read side of the 64-bit register file.
// Resolves Rn/Rm operands from raw register file data with X31-zero and
// MEM/WB forwarding, detects load-use hazards and registers the operands
// into the ID/EX boundary.
// Optional macro REG_READ_PERF_CNT_EN adds forwarding/hazard counters.
//
// Handshake: in_valid qualifies the decode-stage inputs each cycle. out_valid
// marks the registered operands as holding a live instruction. stall_in holds
// the output register, flush clears out_valid, and hazard_stall asks
// fetch/decode to hold the current instruction while a bubble is inserted.
module reg_read_stage #(
   parameter int WIDTH    = 64,
   parameter int AW       = 5,
   parameter int ZERO_REG = 31
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             use_rn,
   input  logic             use_rm,
   input  logic [AW-1:0]    rn_addr,
   input  logic [AW-1:0]    rm_addr,
   input  logic [WIDTH-1:0] rf_rn_data,
   input  logic [WIDTH-1:0] rf_rm_data,
   input  logic             ex_wr_en,
   input  logic             ex_is_load,
   input  logic [AW-1:0]    ex_wr_addr,
   input  logic             mem_wr_en,
   input  logic [AW-1:0]    mem_wr_addr,
   input  logic [WIDTH-1:0] mem_wr_data,
   input  logic             wb_wr_en,
   input  logic [AW-1:0]    wb_wr_addr,
   input  logic [WIDTH-1:0] wb_wr_data,
   input  logic             stall_in,
   input  logic             flush,
   output logic             hazard_stall,
   output logic             out_valid,
   output logic [WIDTH-1:0] rn_data,
   output logic [WIDTH-1:0] rm_data,
   output logic [AW-1:0]    rn_addr_q,
   output logic [AW-1:0]    rm_addr_q
`ifdef REG_READ_PERF_CNT_EN
   ,
   output logic [31:0]      fwd_count,
   output logic [31:0]      hazard_count
`endif
);

   localparam logic [AW-1:0] ZERO_IDX = AW'(ZERO_REG);

   logic [WIDTH-1:0] rn_sel;
   logic [WIDTH-1:0] rm_sel;
   logic             rn_fwd;
   logic             rm_fwd;
   logic             capture;

   // Rn operand select: zero register, then MEM, then WB, then register file.
   // Because the source index is known non-zero on the forwarding branches,
   // a destination of ZERO_REG can never match there.
   always_comb begin
      rn_sel = rf_rn_data;
      rn_fwd = 1'b0;
      if (rn_addr == ZERO_IDX) begin
         rn_sel = '0;
      end else if (mem_wr_en && (mem_wr_addr == rn_addr)) begin
         rn_sel = mem_wr_data;
         rn_fwd = 1'b1;
      end else if (wb_wr_en && (wb_wr_addr == rn_addr)) begin
         rn_sel = wb_wr_data;
         rn_fwd = 1'b1;
      end
   end

   // Rm operand select, same priority as Rn.
   always_comb begin
      rm_sel = rf_rm_data;
      rm_fwd = 1'b0;
      if (rm_addr == ZERO_IDX) begin
         rm_sel = '0;
      end else if (mem_wr_en && (mem_wr_addr == rm_addr)) begin
         rm_sel = mem_wr_data;
         rm_fwd = 1'b1;
      end else if (wb_wr_en && (wb_wr_addr == rm_addr)) begin
         rm_sel = wb_wr_data;
         rm_fwd = 1'b1;
      end
   end

   // Load-use hazard: a load in EX targets a source this instruction uses.
   always_comb begin
      hazard_stall = in_valid && ex_wr_en && ex_is_load && (ex_wr_addr != ZERO_IDX) &&
                     ((use_rn && (ex_wr_addr == rn_addr)) ||
                      (use_rm && (ex_wr_addr == rm_addr)));
      capture      = !flush && !stall_in && !hazard_stall;
   end

   // ID/EX output register: flush > stall (with WB refresh) > bubble > capture.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         rn_data   <= '0;
         rm_data   <= '0;
         rn_addr_q <= '0;
         rm_addr_q <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (stall_in) begin
         // Held operands must not go stale while WB retires their producer;
         // MEM results are picked up later when they reach WB.
         if (wb_wr_en && (wb_wr_addr == rn_addr_q) && (rn_addr_q != ZERO_IDX))
            rn_data <= wb_wr_data;
         if (wb_wr_en && (wb_wr_addr == rm_addr_q) && (rm_addr_q != ZERO_IDX))
            rm_data <= wb_wr_data;
      end else if (hazard_stall) begin
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         rn_data   <= rn_sel;
         rm_data   <= rm_sel;
         rn_addr_q <= rn_addr;
         rm_addr_q <= rm_addr;
      end
   end

`ifdef REG_READ_PERF_CNT_EN
   // Performance counters; both wrap naturally at 32 bits.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fwd_count    <= '0;
         hazard_count <= '0;
      end else begin
         if (capture && (rn_fwd || rm_fwd))
            fwd_count <= fwd_count + 32'd1;
         if (hazard_stall && !stall_in && !flush)
            hazard_count <= hazard_count + 32'd1;
      end
   end
`else
   // Without counters the capture/forward qualifiers have no consumer.
   logic unused_perf;
   assign unused_perf = capture ^ rn_fwd ^ rm_fwd;
`endif

endmodule

// File: doc/reg_read_stage.md
Name: reg_read_stage

Overview:
- Read side of the 64-bit register file.
- Takes the register file's raw read data for Rn/Rm and applies X31-zero and MEM/WB forwarding priority.
- Detects load-use hazards.
- Registers operands into the ID/EX boundary with valid/stall/flush control.
- Sits between register file/decoder and the execute stage of the pipelined CPU.

Parameters:
WIDTH, 64, operand data width
AW, 5, register address width
ZERO_REG, 31, register index that always reads as zero

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active-low
in_valid  in  1  decode stage presents a valid instruction
use_rn  in  1  instruction reads Rn
use_rm  in  1  instruction reads Rm
rn_addr  in  AW  Rn index
rm_addr  in  AW  Rm index
rf_rn_data  in  WIDTH  register file read data for rn_addr
rf_rm_data  in  WIDTH  register file read data for rm_addr
ex_wr_en  in  1  EX-stage instruction writes a register
ex_is_load  in  1  EX-stage instruction is a load
ex_wr_addr  in  AW  EX-stage destination
mem_wr_en  in  1  MEM-stage writes a register
mem_wr_addr  in  AW  MEM-stage destination
mem_wr_data  in  WIDTH  MEM-stage result
wb_wr_en  in  1  WB-stage writes a register (same cycle as register file write)
wb_wr_addr  in  AW  WB destination
wb_wr_data  in  WIDTH  WB data
stall_in  in  1  downstream stall; hold output register
flush  in  1  squash output register contents
hazard_stall  out  1  load-use stall request to fetch/decode
out_valid  out  1  registered operands valid
rn_data  out  WIDTH  registered Rn operand
rm_data  out  WIDTH  registered Rm operand
rn_addr_q  out  AW  registered Rn index
rm_addr_q  out  AW  registered Rm index

Behaviour:
- Reset (rst=0, asynchronous): out_valid=0; rn_data, rm_data, rn_addr_q, rm_addr_q = 0. hazard_stall is combinational; it is 0 while in_valid=0.
- Operand select per source, combinational, highest priority first:
  - addr==ZERO_REG -> 0
  - mem_wr_en and mem_wr_addr==addr -> mem_wr_data
  - wb_wr_en and wb_wr_addr==addr -> wb_wr_data
  - otherwise rf data
- Forward matches never fire on destination ZERO_REG.
- hazard_stall = in_valid & ex_wr_en & ex_is_load & ex_wr_addr!=ZERO_REG & ((use_rn & ex_wr_addr==rn_addr) | (use_rm & ex_wr_addr==rm_addr)).
- Output register update priority each rising edge:
  1. flush -> out_valid=0, data/addr registers unchanged. Flush wins over stall_in.
  2. stall_in -> hold all fields (out_valid unchanged), with hold refresh: if wb_wr_en and wb_wr_addr matches a held index that is not ZERO_REG, that held operand loads wb_wr_data. MEM data is not used for refresh; it reaches WB later.
  3. hazard_stall -> bubble: out_valid=0, data unchanged.
  4. else -> capture selected operands and addresses; out_valid=in_valid.
- Latency: one cycle from in_valid to out_valid.
- An unused source (use_rX=0) is still captured but never triggers a hazard.
- A reset asserted mid-stall clears everything immediately. No state survives.

Optional Feature:
- Macro REG_READ_PERF_CNT_EN.
- When defined, adds outputs fwd_count[31:0] and hazard_count[31:0].
  - fwd_count increments by 1 on each clock edge where a capture (case 4) used MEM or WB forwarding on at least one source.
  - hazard_count increments on each edge where hazard_stall=1 and stall_in=0 and flush=0.
  - Both counters wrap from 0xFFFFFFFF to 0 and reset to 0.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset then capture:
  - Stimulus: rst low 2 cycles, then in_valid=1, rn_addr=3, rf_rn_data=0x11, rm_addr=31, rf_rm_data=0xFF, no writes.
  - Response: next edge out_valid=1, rn_data=0x11, rm_data=0.
- Forward priority:
  - Stimulus: rn_addr=5, mem writes 5 with 0xAAAA, wb writes 5 with 0xBBBB, rf=0xCCCC.
  - Response: rn_data=0xAAAA.
  - Then drop mem_wr_en -> rn_data=0xBBBB next capture.
- Load-use:
  - Stimulus: ex_wr_en=1, ex_is_load=1, ex_wr_addr=7, rm_addr=7, use_rm=1.
  - Response: hazard_stall=1, next out_valid=0.
  - Same with use_rm=0 -> hazard_stall=0.
  - Same with ex_wr_addr=31 -> hazard_stall=0.
- Hold refresh:
  - Stimulus: capture rn_addr=9 with data 0x1, then stall_in=1 while wb writes 9 with 0x2.
  - Response: rn_data becomes 0x2, out_valid stays 1.
  - WB write to 31 during the hold leaves the outputs unchanged.
- Flush vs stall:
  - Stimulus: flush=1 and stall_in=1 in the same cycle.
  - Response: out_valid=0.
- Async reset mid-stall:
  - Stimulus: rst low between edges.
  - Response: outputs 0 immediately, without waiting for an edge.
- Counters (REG_READ_PERF_CNT_EN):
  - Stimulus: 3 forwarded captures plus 2 hazards.
  - Response: fwd_count=3, hazard_count=2.
